// File: rtl/lc2k_reg_file.sv
// LC2K architectural register file: writeback port, two registered read ports, pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data into stalled or new reads.

module lc2k_rd_port #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32
) (
  input  logic [ADDR_W-1:0]                 addr,
  input  logic [NUM_REGS-1:0]               pending,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]   regs,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_reg,
  input  logic [DATA_W-1:0]                 write_value,
  output logic                              ready,
  output logic [DATA_W-1:0]                 data
);
  logic hit;

`ifdef REGFILE_BYPASS_EN
  assign hit = wr_en && (wr_reg == addr);
`else
  logic unused_wb;
  assign unused_wb = ^{wr_en, wr_reg, write_value};
  assign hit = 1'b0;
`endif

  always_comb begin
    ready = (addr == '0) || !pending[addr] || hit;
    if (addr == '0)  data = '0;
    else if (hit)    data = write_value;
    else             data = regs[addr];
  end
endmodule

module lc2k_reg_file #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_reg,
  input  logic [DATA_W-1:0]   write_value,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_reg,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_regA,
  input  logic [ADDR_W-1:0]   rd_regB,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_dataA,
  output logic [DATA_W-1:0]   rd_dataB,
  output logic                busy,
  output logic [NUM_REGS-1:0] pending_mask
);
  typedef enum logic {IDLE, WAIT} state_t;

  state_t                           state, state_nxt;
  logic                             do_read;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;
  logic [NUM_REGS-1:0]              pend_nxt;
  logic [1:0][ADDR_W-1:0]           hold_q, eval_addr;
  logic [1:0]                       ready;
  logic [1:0][DATA_W-1:0]           data;

  // A new request is evaluated on its live addresses; a stalled one on the held copies.
  assign eval_addr[0] = (state == IDLE) ? rd_regA : hold_q[0];
  assign eval_addr[1] = (state == IDLE) ? rd_regB : hold_q[1];
  assign busy         = (state == WAIT);

  for (genvar p = 0; p < 2; p++) begin : g_port
    lc2k_rd_port #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
      .addr        (eval_addr[p]),
      .pending     (pending_mask),
      .regs        (regs_q),
      .wr_en       (wr_en),
      .wr_reg      (wr_reg),
      .write_value (write_value),
      .ready       (ready[p]),
      .data        (data[p])
    );
  end

  always_comb begin
    state_nxt = state;
    do_read   = 1'b0;
    case (state)
      IDLE: if (rd_req) begin
        if (&ready) do_read = 1'b1;
        else        state_nxt = WAIT;
      end
      WAIT: if (&ready) begin
        do_read   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Claim is applied after the clear so a same-cycle claim (newer instruction) wins.
  always_comb begin
    pend_nxt = pending_mask;
    if (wr_en && wr_reg != '0)       pend_nxt[wr_reg]    = 1'b0;
    if (claim_en && claim_reg != '0) pend_nxt[claim_reg] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q       <= '0;
      pending_mask <= '0;
      hold_q       <= '0;
      rd_valid     <= 1'b0;
      rd_dataA     <= '0;
      rd_dataB     <= '0;
    end else begin
      if (wr_en && wr_reg != '0) regs_q[wr_reg] <= write_value;
      pending_mask <= pend_nxt;
      rd_valid     <= do_read;
      if (do_read) begin
        rd_dataA <= data[0];
        rd_dataB <= data[1];
      end
      if (state == IDLE && rd_req) begin
        hold_q[0] <= rd_regA;
        hold_q[1] <= rd_regB;
      end
    end
  end
endmodule

// File: tb/tb_lc2k_reg_file.sv
// Directed vector table plus randomized run against a behavioural register-file model.
module tb_lc2k_reg_file;
  localparam int NR = 8, AW = 3, DW = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, wr_en, claim_en, rd_req;
  logic [AW-1:0] wr_reg, claim_reg, rd_regA, rd_regB;
  logic [DW-1:0] write_value, rd_dataA, rd_dataB;
  logic          rd_valid, busy;
  logic [NR-1:0] pending_mask;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  lc2k_reg_file #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_reg(wr_reg), .write_value(write_value),
    .claim_en(claim_en), .claim_reg(claim_reg), .rd_req(rd_req), .rd_regA(rd_regA),
    .rd_regB(rd_regB), .rd_valid(rd_valid), .rd_dataA(rd_dataA), .rd_dataB(rd_dataB),
    .busy(busy), .pending_mask(pending_mask)
  );

  typedef struct {
    logic rst; logic we; logic [AW-1:0] wr; logic [DW-1:0] wv;
    logic ce; logic [AW-1:0] cr; logic rq; logic [AW-1:0] ra; logic [AW-1:0] rb;
    logic ev; logic [DW-1:0] ea; logic [DW-1:0] eb; logic ebusy; logic [NR-1:0] ep;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic we, int wr, logic [DW-1:0] wv, logic ce, int cr,
                              logic rq, int ra, int rb, logic ev, logic [DW-1:0] ea,
                              logic [DW-1:0] eb, logic ebusy, logic [NR-1:0] ep);
    vec_t v;
    v.rst = rst; v.we = we; v.wr = AW'(wr); v.wv = wv; v.ce = ce; v.cr = AW'(cr);
    v.rq = rq; v.ra = AW'(ra); v.rb = AW'(rb);
    v.ev = ev; v.ea = ea; v.eb = eb; v.ebusy = ebusy; v.ep = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    reset = v.rst; wr_en = v.we; wr_reg = v.wr; write_value = v.wv;
    claim_en = v.ce; claim_reg = v.cr; rd_req = v.rq; rd_regA = v.ra; rd_regB = v.rb;
  endtask

  // Behavioural model: architectural state plus one outstanding request.
  logic [DW-1:0] m_mem [NR];
  bit            m_pend[NR];
  bit            m_wait;
  int            m_ha, m_hb;
  bit            x_valid;
  logic [DW-1:0] x_a, x_b;

  function automatic bit m_rdy(int a);
    return (a == 0) || !m_pend[a] || (BYP && wr_en && int'(wr_reg) == a);
  endfunction

  function automatic logic [DW-1:0] m_val(int a);
    if (a == 0) return '0;
    if (BYP && wr_en && int'(wr_reg) == a) return write_value;
    return m_mem[a];
  endfunction

  function automatic logic [NR-1:0] m_mask();
    logic [NR-1:0] m = '0;
    for (int i = 0; i < NR; i++) m[i] = m_pend[i];
    return m;
  endfunction

  task automatic model_step();
    int ea, eb; bit acc, ok;
    if (reset) begin
      for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
      m_wait = 1'b0; x_valid = 1'b0; x_a = '0; x_b = '0;
    end else begin
      ea = m_wait ? m_ha : int'(rd_regA);
      eb = m_wait ? m_hb : int'(rd_regB);
      acc = m_wait || rd_req;
      ok = m_rdy(ea) && m_rdy(eb);
      x_valid = acc && ok;
      if (x_valid) begin x_a = m_val(ea); x_b = m_val(eb); end
      m_wait = acc && !ok;
      m_ha = ea; m_hb = eb;
      if (wr_en && wr_reg != '0) begin m_mem[wr_reg] = write_value; m_pend[wr_reg] = 1'b0; end
      if (claim_en && claim_reg != '0) m_pend[claim_reg] = 1'b1;
    end
  endtask

  initial begin
    //          rst we wr wv            ce cr rq ra rb  ev ea            eb  busy pend
    tv.push_back(mk(1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 1, 3, 5, 1, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 1, 2, 0, 1, 32'hDEADBEEF, 0, 0, 8'h00));
    tv.push_back(mk(0, 1, 0, 32'h1234,     0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 8'h00));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 1, 0, 0, 1, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 0, 0, 0,            1, 4, 0, 0, 0, 0, 0,            0, 0, 8'h10));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 1, 4, 0, 0, 0,            0, 1, 8'h10));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 1, 1, 1, 0, 0,            0, 1, 8'h10));
    if (BYP) begin
      tv.push_back(mk(0, 1, 4, 32'h55,     0, 0, 0, 0, 0, 1, 32'h55,       0, 0, 8'h00));
      tv.push_back(mk(0, 0, 0, 0,          0, 0, 0, 0, 0, 0, 32'h55,       0, 0, 8'h00));
    end else begin
      tv.push_back(mk(0, 1, 4, 32'h55,     0, 0, 0, 0, 0, 0, 0,            0, 1, 8'h00));
      tv.push_back(mk(0, 0, 0, 0,          0, 0, 0, 0, 0, 1, 32'h55,       0, 0, 8'h00));
    end
    tv.push_back(mk(0, 1, 6, 32'hABC,      1, 6, 0, 0, 0, 0, 32'h55,       0, 0, 8'h40));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 1, 6, 0, 0, 32'h55,       0, 1, 8'h40));
    tv.push_back(mk(1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 1, 1, 32'h11,       0, 0, 0, 0, 0, 0, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 1, 2, 32'h22,       0, 0, 0, 0, 0, 0, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 1, 3, 32'h33,       0, 0, 0, 0, 0, 0, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 1, 7, 32'h77,       0, 0, 0, 0, 0, 0, 0,            0, 0, 8'h00));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 1, 1, 2, 1, 32'h11,       32'h22, 0, 8'h00));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 1, 3, 7, 1, 32'h33,       32'h77, 0, 8'h00));
    tv.push_back(mk(0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 32'h33,       32'h77, 0, 8'h00));

    drive(tv[0]);
    @(posedge clk); #1;
    foreach (tv[i]) begin
      drive(tv[i]);
      @(posedge clk); #1;
      chk($sformatf("vec%0d rd_valid", i), rd_valid, tv[i].ev);
      chk($sformatf("vec%0d rd_dataA", i), rd_dataA, tv[i].ea);
      chk($sformatf("vec%0d rd_dataB", i), rd_dataB, tv[i].eb);
      chk($sformatf("vec%0d busy", i), busy, tv[i].ebusy);
      chk($sformatf("vec%0d pending_mask", i), pending_mask, tv[i].ep);
    end

    for (int c = 0; c < 3000; c++) begin
      reset       = (c == 0) || ($urandom_range(199) == 0);
      wr_en       = ($urandom_range(2) == 0);
      wr_reg      = AW'($urandom_range(NR-1));
      write_value = $urandom;
      claim_en    = ($urandom_range(3) == 0);
      claim_reg   = AW'($urandom_range(NR-1));
      rd_req      = ($urandom_range(1) == 0);
      rd_regA     = AW'($urandom_range(NR-1));
      rd_regB     = AW'($urandom_range(NR-1));
      model_step();
      @(posedge clk); #1;
      chk($sformatf("rnd%0d rd_valid", c), rd_valid, x_valid);
      chk($sformatf("rnd%0d rd_dataA", c), rd_dataA, x_a);
      chk($sformatf("rnd%0d rd_dataB", c), rd_dataB, x_b);
      chk($sformatf("rnd%0d busy", c), busy, m_wait);
      chk($sformatf("rnd%0d pending_mask", c), pending_mask, m_mask());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
